// File: rtl/loop_echo_pkg.sv
// Shared types and saturating arithmetic helpers for the loop echo recorder.
package loop_echo_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPlay   = 2'd2
  } state_e;

  // Clamp a signed value into the range of a w-bit signed number.
  function automatic logic signed [31:0] clamp(input logic signed [31:0] v,
                                               input int unsigned w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    logic signed [31:0] res;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi) begin
      res = hi;
    end else if (v < lo) begin
      res = lo;
    end else begin
      res = v;
    end
    return res;
  endfunction

  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int unsigned w);
    return clamp(a + b, w);
  endfunction

endpackage

// File: rtl/loop_echo_recorder_echo_tap_mixer.sv
// Accumulates attenuated echo taps and presents the saturated mix.
module echo_tap_mixer #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned NUM_TAPS     = 3
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    clear_i,
  input  logic                    add_i,
  input  logic [SAMPLE_WIDTH-1:0] tap_i,
  input  logic [7:0]              shift_i,
  output logic [SAMPLE_WIDTH-1:0] mix_o
);
  import loop_echo_pkg::*;

  localparam int unsigned AccW = SAMPLE_WIDTH + $clog2(NUM_TAPS) + 1;

  logic signed [AccW-1:0] acc_q, acc_d, tap_ext;
  logic signed [31:0]     acc_wide;

  assign tap_ext = $signed({{(AccW - SAMPLE_WIDTH){tap_i[SAMPLE_WIDTH-1]}}, tap_i}) >>> shift_i;

  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + tap_ext;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_wide = {{(32 - AccW){acc_q[AccW-1]}}, acc_q};
  assign mix_o    = SAMPLE_WIDTH'(clamp(acc_wide, SAMPLE_WIDTH));

endmodule

// File: rtl/xilinx_true_dual_port_read_first_2_clock_ram.sv
// Block RAM with a write port (A) and a pipelined read port (B), read-first behaviour.
module xilinx_true_dual_port_read_first_2_clock_ram #(
  parameter int unsigned RAM_WIDTH     = 8,
  parameter int unsigned RAM_ADDR_BITS = 6,
  parameter int unsigned RAM_LATENCY   = 2
) (
  input  logic                     clka_i,
  input  logic                     ena_i,
  input  logic                     wea_i,
  input  logic [RAM_ADDR_BITS-1:0] addra_i,
  input  logic [RAM_WIDTH-1:0]     dina_i,
  input  logic                     clkb_i,
  input  logic                     enb_i,
  input  logic [RAM_ADDR_BITS-1:0] addrb_i,
  output logic [RAM_WIDTH-1:0]     doutb_o
);

  logic [RAM_WIDTH-1:0] mem_q  [2**RAM_ADDR_BITS];
  logic [RAM_WIDTH-1:0] pipe_q [RAM_LATENCY];

  always_ff @(posedge clka_i) begin
    if (ena_i && wea_i) begin
      mem_q[addra_i] <= dina_i;
    end
  end

  // Stage 0 is the array read; the remaining stages model output registers.
  always_ff @(posedge clkb_i) begin
    if (enb_i) begin
      pipe_q[0] <= mem_q[addrb_i];
    end
    for (int i = 1; i < int'(RAM_LATENCY); i++) begin
      pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign doutb_o = pipe_q[RAM_LATENCY-1];

endmodule

// File: rtl/loop_echo_recorder.sv
// Loop recorder: captures a take into BRAM, replays it with a multi-tap decaying echo.
module loop_echo_recorder #(
  parameter int unsigned SAMPLE_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned NUM_TAPS     = 3,
  parameter int unsigned TAP_SPACING  = 1500,
  parameter int unsigned DECAY_SHIFT  = 1,
  parameter int unsigned RAM_LATENCY  = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [SAMPLE_WIDTH-1:0] audio_in,
  input  logic                    audio_valid_in,
  input  logic                    record_in,
  input  logic                    overdub_in,
  output logic [SAMPLE_WIDTH-1:0] single_out,
  output logic [SAMPLE_WIDTH-1:0] echo_out,
  output logic                    out_valid_out,
  output logic                    full_out,
  output logic                    overrun_out,
  output logic [ADDR_WIDTH:0]     loop_len_out
);
  import loop_echo_pkg::*;

  localparam int unsigned Depth      = 2**ADDR_WIDTH;
  localparam int unsigned LenW       = ADDR_WIDTH + 1;
  localparam int unsigned ElapsedMax = NUM_TAPS * TAP_SPACING;
  localparam int unsigned ElW        = $clog2(ElapsedMax + 1);
  localparam int unsigned SlotW      = $clog2(RAM_LATENCY + 1);

  state_e                  state_q, state_d;
  logic                    rec_q;
  logic [LenW-1:0]         write_ptr_q, write_ptr_d, loop_len_q, loop_len_d;
  logic [LenW-1:0]         play_ptr_q, play_ptr_d, base_q, base_d;
  logic [ElW-1:0]          elapsed_q, elapsed_d, elapsed_lat_q, elapsed_lat_d;
  logic                    full_q, full_d;
  logic                    seq_active_q, seq_active_d, done_q, done_d;
  logic [2:0]              tap_q, tap_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic                    od_en_q, od_en_d, od_we_q, od_we_d;
  logic [SAMPLE_WIDTH-1:0] audio_lat_q, audio_lat_d, od_data_q, od_data_d;
  logic [ADDR_WIDTH-1:0]   od_addr_q, od_addr_d;
  logic [SAMPLE_WIDTH-1:0] tap0_q, tap0_d, single_q, single_d, echo_q, echo_d;
  logic                    out_valid_q, out_valid_d, overrun_q, overrun_d;

  logic                    rise, fall;
  logic [31:0]             tap_off, diff;
  logic [ADDR_WIDTH-1:0]   rd_addr, ram_waddr;
  logic                    tap_valid, rd_en, ram_we, mix_clear, mix_add;
  logic [SAMPLE_WIDTH-1:0] rd_data, tap_data, ram_wdata, mix_out;
  logic [7:0]              mix_shift;

  assign rise = record_in & ~rec_q;
  assign fall = ~record_in & rec_q;

  // Tap address wraps backwards around the recorded loop, not the whole buffer.
  assign tap_off   = 32'(tap_q) * TAP_SPACING;
  assign diff      = 32'(base_q) - tap_off;
  assign rd_addr   = ADDR_WIDTH'(diff[31] ? diff + 32'(loop_len_q) : diff);
  assign tap_valid = (32'(elapsed_lat_q) >= tap_off) && (32'(loop_len_q) > tap_off);
  assign tap_data  = tap_valid ? rd_data : '0;
  assign mix_shift = 8'(32'(tap_q) * DECAY_SHIFT);
  assign rd_en     = seq_active_q && (slot_q == '0);

  always_comb begin
    state_d       = state_q;
    write_ptr_d   = write_ptr_q;
    loop_len_d    = loop_len_q;
    play_ptr_d    = play_ptr_q;
    base_d        = base_q;
    elapsed_d     = elapsed_q;
    elapsed_lat_d = elapsed_lat_q;
    full_d        = full_q;
    seq_active_d  = seq_active_q;
    tap_d         = tap_q;
    slot_d        = slot_q;
    done_d        = 1'b0;
    od_en_d       = od_en_q;
    audio_lat_d   = audio_lat_q;
    od_we_d       = 1'b0;
    od_addr_d     = od_addr_q;
    od_data_d     = od_data_q;
    tap0_d        = tap0_q;
    single_d      = single_q;
    echo_d        = echo_q;
    out_valid_d   = 1'b0;
    overrun_d     = 1'b0;
    ram_we        = od_we_q;
    ram_waddr     = od_addr_q;
    ram_wdata     = od_data_q;
    mix_clear     = 1'b0;
    mix_add       = 1'b0;

    if (seq_active_q) begin
      if (slot_q == SlotW'(RAM_LATENCY)) begin
        slot_d  = '0;
        mix_add = 1'b1;
        if (tap_q == 3'd0) begin
          tap0_d    = tap_data;
          od_we_d   = od_en_q;
          od_addr_d = rd_addr;
          od_data_d = SAMPLE_WIDTH'(sat_add(
              {{(32 - SAMPLE_WIDTH){audio_lat_q[SAMPLE_WIDTH-1]}}, audio_lat_q},
              {{(32 - SAMPLE_WIDTH){rd_data[SAMPLE_WIDTH-1]}}, rd_data}, SAMPLE_WIDTH));
        end
        if (tap_q == 3'(NUM_TAPS - 1)) begin
          seq_active_d = 1'b0;
          done_d       = 1'b1;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end else begin
        slot_d = slot_q + SlotW'(1);
      end
    end

    // The accumulator holds the final sum one cycle after the last tap lands.
    if (done_q) begin
      out_valid_d = 1'b1;
      single_d    = tap0_q;
      echo_d      = mix_out;
    end

    if (rise) begin
      state_d      = StRecord;
      write_ptr_d  = '0;
      loop_len_d   = '0;
      full_d       = 1'b0;
      play_ptr_d   = '0;
      elapsed_d    = '0;
      seq_active_d = 1'b0;
      done_d       = 1'b0;
      od_we_d      = 1'b0;
    end else if (fall) begin
      state_d = (loop_len_q != '0) ? StPlay : StIdle;
    end else if (audio_valid_in) begin
      case (state_q)
        StRecord: begin
          if (!full_q) begin
            ram_we      = 1'b1;
            ram_waddr   = write_ptr_q[ADDR_WIDTH-1:0];
            ram_wdata   = audio_in;
            write_ptr_d = write_ptr_q + LenW'(1);
            loop_len_d  = write_ptr_q + LenW'(1);
            full_d      = (write_ptr_q + LenW'(1) == LenW'(Depth));
          end
        end
        StPlay: begin
          overrun_d     = seq_active_q;
          seq_active_d  = 1'b1;
          slot_d        = '0;
          tap_d         = '0;
          done_d        = 1'b0;
          od_we_d       = 1'b0;
          mix_clear     = 1'b1;
          mix_add       = 1'b0;
          base_d        = play_ptr_q;
          elapsed_lat_d = elapsed_q;
          od_en_d       = overdub_in;
          audio_lat_d   = audio_in;
          play_ptr_d    = (play_ptr_q + LenW'(1) == loop_len_q) ? '0 : play_ptr_q + LenW'(1);
          if (elapsed_q != ElW'(ElapsedMax)) begin
            elapsed_d = elapsed_q + ElW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= StIdle;
      rec_q         <= 1'b0;
      write_ptr_q   <= '0;
      loop_len_q    <= '0;
      play_ptr_q    <= '0;
      base_q        <= '0;
      elapsed_q     <= '0;
      elapsed_lat_q <= '0;
      full_q        <= 1'b0;
      seq_active_q  <= 1'b0;
      tap_q         <= '0;
      slot_q        <= '0;
      done_q        <= 1'b0;
      od_en_q       <= 1'b0;
      audio_lat_q   <= '0;
      od_we_q       <= 1'b0;
      od_addr_q     <= '0;
      od_data_q     <= '0;
      tap0_q        <= '0;
      single_q      <= '0;
      echo_q        <= '0;
      out_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rec_q         <= record_in;
      write_ptr_q   <= write_ptr_d;
      loop_len_q    <= loop_len_d;
      play_ptr_q    <= play_ptr_d;
      base_q        <= base_d;
      elapsed_q     <= elapsed_d;
      elapsed_lat_q <= elapsed_lat_d;
      full_q        <= full_d;
      seq_active_q  <= seq_active_d;
      tap_q         <= tap_d;
      slot_q        <= slot_d;
      done_q        <= done_d;
      od_en_q       <= od_en_d;
      audio_lat_q   <= audio_lat_d;
      od_we_q       <= od_we_d;
      od_addr_q     <= od_addr_d;
      od_data_q     <= od_data_d;
      tap0_q        <= tap0_d;
      single_q      <= single_d;
      echo_q        <= echo_d;
      out_valid_q   <= out_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  xilinx_true_dual_port_read_first_2_clock_ram #(
    .RAM_WIDTH    (SAMPLE_WIDTH),
    .RAM_ADDR_BITS(ADDR_WIDTH),
    .RAM_LATENCY  (RAM_LATENCY)
  ) u_ram (
    .clka_i (clk_in),
    .ena_i  (1'b1),
    .wea_i  (ram_we),
    .addra_i(ram_waddr),
    .dina_i (ram_wdata),
    .clkb_i (clk_in),
    .enb_i  (rd_en),
    .addrb_i(rd_addr),
    .doutb_o(rd_data)
  );

  echo_tap_mixer #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_mixer (
    .clk_in  (clk_in),
    .rst_n_in(rst_n_in),
    .clear_i (mix_clear),
    .add_i   (mix_add),
    .tap_i   (tap_data),
    .shift_i (mix_shift),
    .mix_o   (mix_out)
  );

  assign single_out    = single_q;
  assign echo_out      = echo_q;
  assign out_valid_out = out_valid_q;
  assign full_out      = full_q;
  assign overrun_out   = overrun_q;
  assign loop_len_out  = loop_len_q;

endmodule

// File: tb/tb_loop_echo_recorder.sv
// Directed bench for loop_echo_recorder: playback table, overdub, overrun, clamp, full, reset.
module tb_loop_echo_recorder;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic [7:0] audio_in;
  logic       audio_valid_in;
  logic       record_in;
  logic       overdub_in;
  logic [7:0] single_out;
  logic [7:0] echo_out;
  logic       out_valid_out;
  logic       full_out;
  logic       overrun_out;
  logic [6:0] loop_len_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int single;
    int echo;
  } vec_t;
  vec_t vecs [12];

  always #5 clk_in = ~clk_in;

  loop_echo_recorder #(
    .SAMPLE_WIDTH(8),
    .ADDR_WIDTH  (6),
    .NUM_TAPS    (3),
    .TAP_SPACING (4),
    .DECAY_SHIFT (1),
    .RAM_LATENCY (2)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .audio_in      (audio_in),
    .audio_valid_in(audio_valid_in),
    .record_in     (record_in),
    .overdub_in    (overdub_in),
    .single_out    (single_out),
    .echo_out      (echo_out),
    .out_valid_out (out_valid_out),
    .full_out      (full_out),
    .overrun_out   (overrun_out),
    .loop_len_out  (loop_len_out)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic record_take(input int n, input int start, input int inc);
    record_in = 1'b1;
    step();
    for (int i = 0; i < n; i++) begin
      audio_in       = 8'(start + i * inc);
      audio_valid_in = 1'b1;
      step();
      audio_valid_in = 1'b0;
      step();
    end
    record_in = 1'b0;
    step();
  endtask

  // One playback strobe; waits (bounded) for the result pulse.
  task automatic play(input logic od, input int a, output int s, output int e, output int lat);
    s              = 0;
    e              = 0;
    lat            = -1;
    audio_in       = 8'(a);
    overdub_in     = od;
    audio_valid_in = 1'b1;
    step();
    audio_valid_in = 1'b0;
    overdub_in     = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (out_valid_out) begin
        lat = c;
        s   = int'($signed(single_out));
        e   = int'($signed(echo_out));
        break;
      end
    end
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_single"}, int'(single_out), 0);
    check({tag, "_echo"}, int'(echo_out), 0);
    check({tag, "_valid"}, int'(out_valid_out), 0);
    check({tag, "_full"}, int'(full_out), 0);
    check({tag, "_overrun"}, int'(overrun_out), 0);
    check({tag, "_loop_len"}, int'(loop_len_out), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, lat, vcnt;

    // Loop 1..10: tap1 joins at elapsed 4, tap2 at elapsed 8.
    vecs[0]  = '{1, 1};
    vecs[1]  = '{2, 2};
    vecs[2]  = '{3, 3};
    vecs[3]  = '{4, 4};
    vecs[4]  = '{5, 5};
    vecs[5]  = '{6, 7};
    vecs[6]  = '{7, 8};
    vecs[7]  = '{8, 10};
    vecs[8]  = '{9, 11};
    vecs[9]  = '{10, 13};
    vecs[10] = '{1, 4};
    vecs[11] = '{2, 7};

    rst_n_in       = 1'b0;
    audio_in       = '0;
    audio_valid_in = 1'b0;
    record_in      = 1'b0;
    overdub_in     = 1'b0;
    #12;
    check_all_zero("reset");
    #1;
    rst_n_in = 1'b1;
    step();

    record_take(10, 1, 1);
    check("t1_loop_len", int'(loop_len_out), 10);
    check("t1_full", int'(full_out), 0);
    for (int i = 0; i < 12; i++) begin
      play(1'b0, 0, s, e, lat);
      check($sformatf("t1_latency[%0d]", i), lat, 10);
      check($sformatf("t1_single[%0d]", i), s, vecs[i].single);
      check($sformatf("t1_echo[%0d]", i), e, vecs[i].echo);
    end

    // Overdub at play_ptr 2: reads 3, writes back 3+20.
    play(1'b1, 20, s, e, lat);
    check("od_single", s, 3);
    check("od_echo", e, 8);
    for (int i = 0; i < 9; i++) begin
      play(1'b0, 0, s, e, lat);
      check($sformatf("od_fill_latency[%0d]", i), lat, 10);
    end
    play(1'b0, 0, s, e, lat);
    check("od_replay_single", s, 23);
    check("od_replay_echo", e, 28);

    // Overrun burst from play_ptr 3 through the wrap to play_ptr 1.
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      audio_valid_in = 1'b1;
      step();
      audio_valid_in = 1'b0;
      check($sformatf("ovr_pulse[%0d]", i), int'(overrun_out), (i == 0) ? 0 : 1);
      if (out_valid_out) vcnt++;
      if (i < 8) begin
        step();
        if (out_valid_out) vcnt++;
        step();
        if (out_valid_out) vcnt++;
      end
    end
    check("ovr_no_valid", vcnt, 0);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (out_valid_out) begin
        lat = c;
        s   = int'($signed(single_out));
        e   = int'($signed(echo_out));
        break;
      end
    end
    check("ovr_final_latency", lat, 10);
    check("ovr_final_single", s, 2);
    check("ovr_final_echo", e, 7);
    step();
    check("ovr_cleared", int'(overrun_out), 0);
    play(1'b0, 0, s, e, lat);
    check("ovr_wrap_single", s, 23);

    // Constant +100 take: two taps once warmed up saturate at 127.
    record_take(8, 100, 0);
    check("t3_loop_len", int'(loop_len_out), 8);
    for (int n = 1; n <= 10; n++) begin
      play(1'b0, 0, s, e, lat);
      check($sformatf("t3_single[%0d]", n), s, 100);
      check($sformatf("t3_echo[%0d]", n), e, (n <= 4) ? 100 : 127);
    end

    // Overlong take: buffer fills at 64, later strobes dropped.
    record_in = 1'b1;
    step();
    for (int i = 0; i < 70; i++) begin
      audio_in       = 8'(i + 1);
      audio_valid_in = 1'b1;
      step();
      audio_valid_in = 1'b0;
      if (i == 62) check("t4_full_before", int'(full_out), 0);
      if (i == 63) check("t4_full_at_64", int'(full_out), 1);
      step();
    end
    check("t4_loop_len", int'(loop_len_out), 64);
    record_in = 1'b0;
    step();
    check("t4_full_held", int'(full_out), 1);
    play(1'b0, 0, s, e, lat);
    check("t4_latency", lat, 10);
    check("t4_addr0_kept", s, 1);

    // Asynchronous reset in the middle of a tap sequence.
    audio_valid_in = 1'b1;
    step();
    audio_valid_in = 1'b0;
    step();
    step();
    step();
    rst_n_in = 1'b0;
    #1;
    check_all_zero("t6_async");
    #3;
    rst_n_in = 1'b1;
    step();
    record_take(3, 50, 10);
    check("t6_loop_len", int'(loop_len_out), 3);
    play(1'b0, 0, s, e, lat);
    check("t6_latency", lat, 10);
    check("t6_single", s, 50);
    check("t6_echo", e, 50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
